sdram_write_seg: RTL



---
 rtl/sdram_write_seg_if.sv | 51 +++++
 rtl/sdram_write_seg.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sdram_write_seg_if.sv
// Write-engine bus: arbiter/FIFO side (master) to the write-burst engine (slave).
// Optional byte-mask signals exist only when SDRAM_WR_DQM_EN is defined.
interface sdram_write_seg_if #(
  parameter int DATA_W = 16,
  parameter int BA_W   = 2,
  parameter int ROW_W  = 13,
  parameter int COL_W  = 9,
  parameter int LEN_W  = 10
);
  logic                          init_end;
  logic                          wr_en;
  logic [BA_W+ROW_W+COL_W-1:0]   wr_addr;
  logic [LEN_W-1:0]              wr_burst_len;
  logic [DATA_W-1:0]             wr_data;
  logic [3:0]                    wr_cmd;
  logic [BA_W-1:0]               wr_ba;
  logic [ROW_W-1:0]              wr_sdram_addr;
  logic                          wr_sdram_en;
  logic [DATA_W-1:0]             wr_sdram_data;
  logic                          wr_ack;
  logic                          wr_end;
  logic                          wr_busy;
`ifdef SDRAM_WR_DQM_EN
  logic [DATA_W/8-1:0]           wr_be;
  logic [DATA_W/8-1:0]           wr_dqm;

  modport master (
    output init_end, wr_en, wr_addr, wr_burst_len, wr_data, wr_be,
    input  wr_cmd, wr_ba, wr_sdram_addr, wr_sdram_en, wr_sdram_data,
           wr_ack, wr_end, wr_busy, wr_dqm
  );

  modport slave (
    input  init_end, wr_en, wr_addr, wr_burst_len, wr_data, wr_be,
    output wr_cmd, wr_ba, wr_sdram_addr, wr_sdram_en, wr_sdram_data,
           wr_ack, wr_end, wr_busy, wr_dqm
  );
`else
  modport master (
    output init_end, wr_en, wr_addr, wr_burst_len, wr_data,
    input  wr_cmd, wr_ba, wr_sdram_addr, wr_sdram_en, wr_sdram_data,
           wr_ack, wr_end, wr_busy
  );

  modport slave (
    input  init_end, wr_en, wr_addr, wr_burst_len, wr_data,
    output wr_cmd, wr_ba, wr_sdram_addr, wr_sdram_en, wr_sdram_data,
           wr_ack, wr_end, wr_busy
  );
`endif
endinterface

// File: rtl/sdram_write_seg.sv
// SDRAM full-page write-burst engine. Bursts that cross a column page are
// split into consecutive row segments; tWR is honoured before each precharge.
// Optional feature macro: SDRAM_WR_DQM_EN (byte-enable input / DQM output).
// Without it there is no DQM port and the external DQM is tied low above us.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for an accepted request
// ACTIVE   | issue ACTIVE for current bank/row, compute segment length
// TRCD     | NOP wait, TRCD cycles
// WRITE    | issue WRITE at current column, first FIFO read
// DATA     | seg cycles of data; BSTOP generated in the last one
// TWR      | NOP wait, TWR cycles
// PCH      | issue PRECHARGE all banks
// TRP      | NOP wait, TRP cycles; advance address, loop or finish
// END      | generate one-cycle wr_end
module sdram_write_seg #(
  parameter int DATA_W = 16,
  parameter int BA_W   = 2,
  parameter int ROW_W  = 13,
  parameter int COL_W  = 9,
  parameter int LEN_W  = 10,
  parameter int TRCD   = 2,
  parameter int TWR    = 2,
  parameter int TRP    = 2
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  sdram_write_seg_if.slave bus
);

  localparam int AW = BA_W + ROW_W + COL_W;
  // wide enough to hold 2^COL_W as well as any burst length
  localparam int SW = ((LEN_W > COL_W) ? LEN_W : COL_W) + 1;

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_BSTOP = 4'b0110;
  localparam logic [3:0] CMD_PCH   = 4'b0010;

  localparam logic [LEN_W-1:0] TRCD_LD = LEN_W'(TRCD - 1);
  localparam logic [LEN_W-1:0] TWR_LD  = LEN_W'(TWR - 1);
  localparam logic [LEN_W-1:0] TRP_LD  = LEN_W'(TRP - 1);
  localparam logic [ROW_W-1:0] ADDR_A10 = ROW_W'(1) << 10;

  typedef enum logic [3:0] {
    S_IDLE, S_ACTIVE, S_TRCD, S_WRITE, S_DATA, S_TWR, S_PCH, S_TRP, S_END
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] tmr;
  logic [AW-1:0]    cur_addr;
  logic [LEN_W-1:0] remain;
  logic [LEN_W-1:0] seg;
  logic [3:0]       cmd_q;
  logic [BA_W-1:0]  ba_q;
  logic [ROW_W-1:0] addr_q;
  logic             en_q;
  logic             end_q;
  logic             busy_q;

  logic [BA_W-1:0]  cur_ba;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  logic [SW-1:0]    room;
  logic [LEN_W-1:0] seg_calc;
  logic             ack;

  assign cur_ba  = cur_addr[AW-1 -: BA_W];
  assign cur_row = cur_addr[COL_W +: ROW_W];
  assign cur_col = cur_addr[COL_W-1:0];

  // words left in the current column page; a segment never crosses it
  assign room     = (SW'(1) << COL_W) - SW'(cur_col);
  assign seg_calc = (SW'(remain) < room) ? remain : room[LEN_W-1:0];

  // FIFO strobe: WRITE plus all but the last DATA cycle gives seg words
  assign ack = (state == S_WRITE) || ((state == S_DATA) && (tmr != '0));

  assign bus.wr_ack        = ack;
  assign bus.wr_cmd        = cmd_q;
  assign bus.wr_ba         = ba_q;
  assign bus.wr_sdram_addr = addr_q;
  assign bus.wr_sdram_en   = en_q;
  assign bus.wr_sdram_data = en_q ? bus.wr_data : '0;
  assign bus.wr_end        = end_q;
  assign bus.wr_busy       = busy_q;

  // Sequencer: state, timers, address tracking and registered command outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= S_IDLE;
      tmr      <= '0;
      cur_addr <= '0;
      remain   <= '0;
      seg      <= '0;
      cmd_q    <= CMD_NOP;
      ba_q     <= '1;
      addr_q   <= '1;
      en_q     <= 1'b0;
      end_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cmd_q  <= CMD_NOP;
      ba_q   <= '1;
      addr_q <= '1;
      end_q  <= 1'b0;
      en_q   <= ack;
      case (state)
        S_IDLE: begin
          if (bus.init_end && bus.wr_en && (bus.wr_burst_len != '0)) begin
            cur_addr <= bus.wr_addr;
            remain   <= bus.wr_burst_len;
            busy_q   <= 1'b1;
            state    <= S_ACTIVE;
          end else begin
            busy_q   <= 1'b0;
          end
        end
        S_ACTIVE: begin
          cmd_q  <= CMD_ACT;
          ba_q   <= cur_ba;
          addr_q <= cur_row;
          seg    <= seg_calc;
          tmr    <= TRCD_LD;
          state  <= S_TRCD;
        end
        S_TRCD: begin
          if (tmr == '0) state <= S_WRITE;
          else           tmr   <= tmr - 1'b1;
        end
        S_WRITE: begin
          cmd_q  <= CMD_WRITE;
          ba_q   <= cur_ba;
          addr_q <= ROW_W'(cur_col);
          tmr    <= seg - 1'b1;
          state  <= S_DATA;
        end
        S_DATA: begin
          if (tmr == '0) begin
            cmd_q <= CMD_BSTOP;
            tmr   <= TWR_LD;
            state <= S_TWR;
          end else begin
            tmr   <= tmr - 1'b1;
          end
        end
        S_TWR: begin
          if (tmr == '0) state <= S_PCH;
          else           tmr   <= tmr - 1'b1;
        end
        S_PCH: begin
          cmd_q  <= CMD_PCH;
          addr_q <= ADDR_A10;
          tmr    <= TRP_LD;
          state  <= S_TRP;
        end
        S_TRP: begin
          if (tmr == '0) begin
            remain   <= remain - seg;
            cur_addr <= cur_addr + AW'(seg);
            state    <= (remain != seg) ? S_ACTIVE : S_END;
          end else begin
            tmr      <= tmr - 1'b1;
          end
        end
        S_END: begin
          end_q <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SDRAM_WR_DQM_EN
  logic [DATA_W/8-1:0] dqm_q;

  // Byte mask travels with the DQ enable; masked whenever DQ is not driven
  always_ff @(posedge sys_clk) begin
    if (sys_rst) dqm_q <= '1;
    else         dqm_q <= ack ? ~bus.wr_be : '1;
  end

  assign bus.wr_dqm = dqm_q;
`endif

endmodule
